// File: rtl/cond_resolve_pkg.sv
// Shared flag layout, x86 tttn condition encodings and resolve-stage FSM states.
// Also holds the bypass merge used wherever flags are read in the write cycle.
package cond_resolve_pkg;

  localparam int CC_W = 18;
  typedef logic [CC_W-1:0] cc_t;

  localparam int CF_B = 0;
  localparam int PF_B = 1;
  localparam int AF_B = 2;
  localparam int ZF_B = 3;
  localparam int SF_B = 4;
  localparam int DF_B = 7;
  localparam int OF_B = 8;

  localparam logic [3:0] TTTN_O  = 4'h0;
  localparam logic [3:0] TTTN_NO = 4'h1;
  localparam logic [3:0] TTTN_B  = 4'h2;
  localparam logic [3:0] TTTN_NB = 4'h3;
  localparam logic [3:0] TTTN_E  = 4'h4;
  localparam logic [3:0] TTTN_NE = 4'h5;
  localparam logic [3:0] TTTN_BE = 4'h6;
  localparam logic [3:0] TTTN_A  = 4'h7;
  localparam logic [3:0] TTTN_S  = 4'h8;
  localparam logic [3:0] TTTN_NS = 4'h9;
  localparam logic [3:0] TTTN_P  = 4'hA;
  localparam logic [3:0] TTTN_NP = 4'hB;
  localparam logic [3:0] TTTN_L  = 4'hC;
  localparam logic [3:0] TTTN_GE = 4'hD;
  localparam logic [3:0] TTTN_LE = 4'hE;
  localparam logic [3:0] TTTN_G  = 4'hF;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_SQUASH = 1'b1;

  // Bits outside the write mask keep the register value.
  function automatic cc_t merge_flags(cc_t cur, logic wr_vld, cc_t wr_dat, cc_t wr_mask);
    merge_flags = wr_vld ? ((wr_dat & wr_mask) | (cur & ~wr_mask)) : cur;
  endfunction

endpackage

// File: rtl/cond_resolve_cc_eval.sv
// Combinational tttn evaluator over flags with same-cycle write bypass; zero latency,
// no flow control. Shared by the branch resolver and the CMOV datapath.
module cc_eval
  import cond_resolve_pkg::*;
(
  input  logic [CC_W-1:0] cc_i,
  input  logic            cc_wr_valid_i,
  input  logic [CC_W-1:0] cc_wr_data_i,
  input  logic [CC_W-1:0] cc_wr_mask_i,
  input  logic [3:0]      cond_i,
  output logic            cond_true_o
);

  cc_t  eff;
  logic cf, pf, zf, sf, of_f, lt;
  logic unused_flags;

  assign eff  = merge_flags(cc_i, cc_wr_valid_i, cc_wr_data_i, cc_wr_mask_i);
  assign cf   = eff[CF_B];
  assign pf   = eff[PF_B];
  assign zf   = eff[ZF_B];
  assign sf   = eff[SF_B];
  assign of_f = eff[OF_B];
  assign lt   = sf ^ of_f;

  // AF, DF and the reserved upper bits never feed a condition.
  assign unused_flags = ^{eff[CC_W-1:OF_B+1], eff[DF_B:SF_B+1], eff[AF_B]};

  always_comb begin
    cond_true_o = 1'b0;
    case (cond_i)
      TTTN_O:  cond_true_o = of_f;
      TTTN_NO: cond_true_o = !of_f;
      TTTN_B:  cond_true_o = cf;
      TTTN_NB: cond_true_o = !cf;
      TTTN_E:  cond_true_o = zf;
      TTTN_NE: cond_true_o = !zf;
      TTTN_BE: cond_true_o = cf | zf;
      TTTN_A:  cond_true_o = !(cf | zf);
      TTTN_S:  cond_true_o = sf;
      TTTN_NS: cond_true_o = !sf;
      TTTN_P:  cond_true_o = pf;
      TTTN_NP: cond_true_o = !pf;
      TTTN_L:  cond_true_o = lt;
      TTTN_GE: cond_true_o = !lt;
      TTTN_LE: cond_true_o = zf | lt;
      TTTN_G:  cond_true_o = !(zf | lt);
    endcase
  end

endmodule

// File: rtl/cond_resolve.sv
// Resolves Jcc/SETcc/CMOVcc conditions, one-cycle registered result with valid/ready
// backpressure; a mispredicted branch pulses resteer and blocks input until resteer_ack.
module cond_resolve
  import cond_resolve_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_is_br,
  input  logic [3:0]        in_cond,
  input  logic              in_pred_taken,
  input  logic [ADDR_W-1:0] in_target,
  input  logic [ADDR_W-1:0] in_fallthru,
  input  logic [CC_W-1:0]   cc,
  input  logic              cc_wr_valid,
  input  logic [CC_W-1:0]   cc_wr_data,
  input  logic [CC_W-1:0]   cc_wr_mask,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_cond_true,
  output logic              out_is_br,
  output logic              resteer,
  output logic [ADDR_W-1:0] resteer_eip,
  input  logic              resteer_ack,
  output logic [CNT_W-1:0]  br_count,
  output logic [CNT_W-1:0]  mispred_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [0:0]        state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic              cond_true_q, cond_true_d;
  logic              is_br_q, is_br_d;
  logic              resteer_q, resteer_d;
  logic [ADDR_W-1:0] eip_q, eip_d;
  logic [CNT_W-1:0]  br_q, br_d;
  logic [CNT_W-1:0]  mis_q, mis_d;
  logic              cond_true, capture, mispred;

  cc_eval u_cc_eval (
    .cc_i          (cc),
    .cc_wr_valid_i (cc_wr_valid),
    .cc_wr_data_i  (cc_wr_data),
    .cc_wr_mask_i  (cc_wr_mask),
    .cond_i        (in_cond),
    .cond_true_o   (cond_true)
  );

  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign capture  = in_valid && in_ready;
  assign mispred  = capture && in_is_br && (cond_true != in_pred_taken);

  always_comb begin
    out_valid_d = out_valid_q;
    cond_true_d = cond_true_q;
    is_br_d     = is_br_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (capture) begin
      out_valid_d = 1'b1;
      cond_true_d = cond_true;
      is_br_d     = in_is_br;
    end
  end

  always_comb begin
    resteer_d = mispred;
    eip_d     = eip_q;
    if (mispred) eip_d = cond_true ? in_target : in_fallthru;
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (mispred) state_d = ST_SQUASH;
      ST_SQUASH: if (resteer_ack) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Both counters saturate at all-ones rather than wrapping.
  always_comb begin
    br_d  = br_q;
    mis_d = mis_q;
    if (capture && in_is_br && !(&br_q)) br_d = br_q + CNT_ONE;
    if (mispred && !(&mis_q)) mis_d = mis_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      cond_true_q <= 1'b0;
      is_br_q     <= 1'b0;
      resteer_q   <= 1'b0;
      eip_q       <= '0;
      br_q        <= '0;
      mis_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      cond_true_q <= cond_true_d;
      is_br_q     <= is_br_d;
      resteer_q   <= resteer_d;
      eip_q       <= eip_d;
      br_q        <= br_d;
      mis_q       <= mis_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_cond_true = cond_true_q;
  assign out_is_br     = is_br_q;
  assign resteer       = resteer_q;
  assign resteer_eip   = eip_q;
  assign br_count      = br_q;
  assign mispred_count = mis_q;

endmodule

// File: tb/tb_cond_resolve.sv
// Bench for cond_resolve: condition vector table plus hand-built stall, resteer,
// reset and counter-saturation sequences, checked against a cycle model and scoreboard.
module tb_cond_resolve;

  logic        clk, rst;
  logic        in_valid, in_ready, in_is_br, in_pred_taken;
  logic [3:0]  in_cond;
  logic [31:0] in_target, in_fallthru;
  logic [17:0] cc, cc_wr_data, cc_wr_mask;
  logic        cc_wr_valid;
  logic        out_valid, out_ready, out_cond_true, out_is_br;
  logic        resteer, resteer_ack;
  logic [31:0] resteer_eip;
  logic [15:0] br_count, mispred_count;

  cond_resolve #(.ADDR_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_br(in_is_br), .in_cond(in_cond),
    .in_pred_taken(in_pred_taken), .in_target(in_target), .in_fallthru(in_fallthru),
    .cc(cc), .cc_wr_valid(cc_wr_valid), .cc_wr_data(cc_wr_data), .cc_wr_mask(cc_wr_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_cond_true(out_cond_true),
    .out_is_br(out_is_br), .resteer(resteer), .resteer_eip(resteer_eip),
    .resteer_ack(resteer_ack), .br_count(br_count), .mispred_count(mispred_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic ct; logic br; } exp_t;
  typedef struct {
    logic [17:0] cc; logic wv; logic [17:0] wd; logic [17:0] wm; logic [3:0] cond; logic exp;
  } vec_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic        m_sq, m_ov, m_rs;
  logic [31:0] m_eip;
  logic [15:0] m_br, m_mis;
  logic        ovr_vld, ovr_val;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic model_cond(logic [17:0] c, logic wv, logic [17:0] wd,
                                      logic [17:0] wm, logic [3:0] cond);
    logic [17:0] f;
    logic        b, lt;
    f = c;
    if (wv) for (int i = 0; i < 18; i++) if (wm[i]) f[i] = wd[i];
    lt = f[4] ^ f[8];
    case (cond[3:1])
      3'd0: b = f[8];
      3'd1: b = f[0];
      3'd2: b = f[3];
      3'd3: b = f[0] | f[3];
      3'd4: b = f[4];
      3'd5: b = f[1];
      3'd6: b = lt;
      default: b = f[3] | lt;
    endcase
    return b ^ cond[0];
  endfunction

  task automatic model_reset();
    m_sq = 0; m_ov = 0; m_rs = 0; m_eip = '0; m_br = '0; m_mis = '0;
    sb.delete();
  endtask

  // Sample settled outputs, advance the model one cycle, then step past the clock edge.
  task automatic tick();
    logic exp_rdy, c, nrs;
    exp_t e;
    #1;
    exp_rdy = !m_sq && (!m_ov || out_ready);
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, m_ov);
    chk("resteer", resteer, m_rs);
    if (m_rs) chk("resteer_eip", resteer_eip, m_eip);
    chk("br_count", br_count, m_br);
    chk("mispred_count", mispred_count, m_mis);
    if (m_ov) begin
      chk("out_cond_true", out_cond_true, sb[0].ct);
      chk("out_is_br", out_is_br, sb[0].br);
      if (out_ready) begin
        void'(sb.pop_front());
        m_ov = 0;
      end
    end
    nrs = 0;
    if (in_valid && exp_rdy) begin
      c = ovr_vld ? ovr_val : model_cond(cc, cc_wr_valid, cc_wr_data, cc_wr_mask, in_cond);
      e.ct = c; e.br = in_is_br;
      sb.push_back(e);
      m_ov = 1;
      if (in_is_br && m_br != 16'hFFFF) m_br++;
      if (in_is_br && c != in_pred_taken) begin
        nrs = 1;
        m_eip = c ? in_target : in_fallthru;
        if (m_mis != 16'hFFFF) m_mis++;
      end
    end
    if (m_sq && resteer_ack) m_sq = 0;
    if (nrs) m_sq = 1;
    m_rs = nrs;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(logic [17:0] c, logic wv, logic [17:0] wd, logic [17:0] wm,
                        logic [3:0] cond, logic br, logic pred);
    cc = c; cc_wr_valid = wv; cc_wr_data = wd; cc_wr_mask = wm;
    in_cond = cond; in_is_br = br; in_pred_taken = pred;
  endtask

  vec_t vt[$];

  initial begin
    rst = 0; in_valid = 0; out_ready = 1; resteer_ack = 0; ovr_vld = 0; ovr_val = 0;
    in_target = 32'h2000; in_fallthru = 32'h1000;
    set_op(18'h0, 0, 18'h0, 18'h0, 4'h0, 0, 0);
    model_reset();
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_cond_true", out_cond_true, 0);
    chk("rst_is_br", out_is_br, 0);
    chk("rst_resteer", resteer, 0);
    chk("rst_eip", resteer_eip, 0);
    chk("rst_br_count", br_count, 0);
    chk("rst_mis_count", mispred_count, 0);
    @(posedge clk); #1; rst = 1;

    // ZF set, JE predicted taken: resolves true, no resteer.
    set_op(18'h008, 0, 18'h0, 18'h0, 4'h4, 1, 1); in_valid = 1; tick(); in_valid = 0;
    chk("je_cond_true", out_cond_true, 1);
    chk("je_no_resteer", resteer, 0);
    chk("je_br_count", br_count, 1);
    tick();

    vt = '{
      '{18'h000, 0, 18'h000, 18'h000, 4'h0, 0}, '{18'h100, 0, 18'h000, 18'h000, 4'h0, 1},
      '{18'h100, 0, 18'h000, 18'h000, 4'h1, 0}, '{18'h001, 0, 18'h000, 18'h000, 4'h2, 1},
      '{18'h000, 0, 18'h000, 18'h000, 4'h3, 1}, '{18'h008, 0, 18'h000, 18'h000, 4'h6, 1},
      '{18'h001, 0, 18'h000, 18'h000, 4'h7, 0}, '{18'h010, 0, 18'h000, 18'h000, 4'h8, 1},
      '{18'h002, 0, 18'h000, 18'h000, 4'hA, 1}, '{18'h002, 0, 18'h000, 18'h000, 4'hB, 0},
      '{18'h010, 0, 18'h000, 18'h000, 4'hC, 1}, '{18'h110, 0, 18'h000, 18'h000, 4'hC, 0},
      '{18'h110, 0, 18'h000, 18'h000, 4'hD, 1}, '{18'h008, 0, 18'h000, 18'h000, 4'hE, 1},
      '{18'h100, 0, 18'h000, 18'h000, 4'hF, 0}, '{18'h000, 1, 18'h110, 18'h110, 4'hC, 0},
      '{18'h008, 1, 18'h000, 18'h008, 4'h4, 0}, '{18'h000, 0, 18'h008, 18'h008, 4'h4, 0},
      '{18'h008, 1, 18'h000, 18'h100, 4'h4, 1}, '{18'h084, 0, 18'h000, 18'h000, 4'h5, 1}
    };
    ovr_vld = 1;
    for (int i = 0; i < vt.size(); i++) begin
      set_op(vt[i].cc, vt[i].wv, vt[i].wd, vt[i].wm, vt[i].cond, 0, 0);
      ovr_val = vt[i].exp;
      in_valid = 1;
      tick();
    end
    ovr_vld = 0; in_valid = 0;
    tick(); tick();

    // Mispredict: JE predicted taken with ZF clear goes to fallthrough.
    set_op(18'h0, 0, 18'h0, 18'h0, 4'h4, 1, 1); in_fallthru = 32'h1000; in_valid = 1;
    tick();
    chk("mp_resteer", resteer, 1);
    chk("mp_eip", resteer_eip, 32'h1000);
    chk("mp_count", mispred_count, 1);
    repeat (3) tick();
    chk("squash_in_ready", in_ready, 0);
    resteer_ack = 1; tick(); resteer_ack = 0; in_valid = 0;
    tick(); tick();

    // Ack coincident with the resteer pulse.
    set_op(18'h0, 0, 18'h0, 18'h0, 4'h5, 1, 0); in_target = 32'h2000; in_valid = 1;
    tick(); in_valid = 0; resteer_ack = 1; tick(); resteer_ack = 0; tick();
    // Ack in the capture cycle is seen in IDLE and ignored.
    in_valid = 1; resteer_ack = 1; tick(); in_valid = 0; resteer_ack = 0;
    tick(); tick();
    resteer_ack = 1; tick(); resteer_ack = 0; tick();

    // Back-pressure with back-to-back inputs, then drain and fill together.
    out_ready = 0;
    set_op(18'h001, 0, 18'h0, 18'h0, 4'h2, 0, 0); in_valid = 1; tick();
    set_op(18'h001, 0, 18'h0, 18'h0, 4'h3, 0, 0);
    repeat (3) tick();
    chk("stall_in_ready", in_ready, 0);
    chk("stall_cond_true", out_cond_true, 1);
    out_ready = 1; tick();
    chk("fill_cond_true", out_cond_true, 0);
    in_valid = 0; tick(); tick();

    // Asynchronous reset while squashing with a result held.
    out_ready = 0;
    set_op(18'h0, 0, 18'h0, 18'h0, 4'h4, 1, 1); in_valid = 1; tick(); in_valid = 0;
    chk("pre_rst_valid", out_valid, 1);
    rst = 0; #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_resteer", resteer, 0);
    chk("arst_br_count", br_count, 0);
    chk("arst_mis_count", mispred_count, 0);
    repeat (2) @(posedge clk);
    #1; rst = 1; model_reset(); out_ready = 1;
    tick();
    chk("post_rst_in_ready", in_ready, 1);

    // Saturation of the branch counter.
    set_op(18'h0, 0, 18'h0, 18'h0, 4'h5, 1, 1); in_valid = 1;
    repeat (65536) tick();
    in_valid = 0; tick();
    chk("br_sat", br_count, 16'hFFFF);
    chk("br_sat_mis", mispred_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cond_resolve.md
Name: cond_resolve

Overview:
- Execute-stage consumer of the architectural flags held in the EFLAG register.
- Evaluates the x86 tttn condition for Jcc, SETcc and CMOVcc micro-ops against the current flags, with same-cycle bypass of the flag update being written.
- Compares the outcome with the front-end prediction and issues a resteer request on mispredict.
- Sits between the execute issue latch and writeback; its resteer output drives the is_resteer restore input of the flag register.

Parameters:
- ADDR_W, 32, width of EIP values.
- CNT_W, 16, width of saturating statistics counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset, active-low, asynchronous
- in_valid  in  1  micro-op present
- in_ready  out  1  stage can accept a micro-op
- in_is_br  in  1  micro-op is a conditional branch; 0 means SETcc/CMOVcc, which never resteers
- in_cond  in  4  x86 tttn condition field
- in_pred_taken  in  1  front-end prediction
- in_target  in  ADDR_W  taken EIP
- in_fallthru  in  ADDR_W  not-taken EIP
- cc  in  18  current flag register output; cf0 pf1 af2 zf3 sf4 df7 of8
- cc_wr_valid  in  1  flag update being written this cycle
- cc_wr_data  in  18  flag values being written
- cc_wr_mask  in  18  bits being written
- out_valid  out  1  result held
- out_ready  in  1  writeback accepts
- out_cond_true  out  1  evaluated condition
- out_is_br  out  1  registered in_is_br
- resteer  out  1  one-cycle mispredict pulse
- resteer_eip  out  ADDR_W  corrected EIP, valid with resteer
- resteer_ack  in  1  front end has redirected
- br_count  out  CNT_W  resolved branches, saturating
- mispred_count  out  CNT_W  mispredicted branches, saturating

Behaviour:
- Reset values: all outputs 0, FSM in IDLE. Reset is asynchronous and takes effect mid-operation: the held result is dropped and any pending squash is abandoned.
- Effective flags:
  - When cc_wr_valid=1: eff = (cc_wr_data & cc_wr_mask) | (cc & ~cc_wr_mask).
  - Otherwise eff = cc.
- Condition table, selected by in_cond[3:1]:
  - 0: OF
  - 1: CF
  - 2: ZF
  - 3: CF|ZF
  - 4: SF
  - 5: PF
  - 6: SF^OF
  - 7: ZF|(SF^OF)
  - in_cond[0]=1 inverts the result.
- Pipeline:
  - Single output register with one cycle of latency.
  - A transfer occurs when in_valid && in_ready; the result is captured at that clock edge.
  - in_ready = (state==IDLE) && (!out_valid || out_ready). Simultaneous drain and fill is allowed, giving full throughput.
  - out_valid holds, with stable data, while out_ready=0.
- FSM:
  - IDLE: on a capture with in_is_br=1 and cond_true != in_pred_taken:
    - assert resteer for exactly that cycle, registered with the capture;
    - resteer_eip = cond_true ? in_target : in_fallthru;
    - go to SQUASH.
  - SQUASH: in_ready=0. Incoming micro-ops are wrong-path and are not captured. The held result still drains. On resteer_ack go to IDLE.
  - If resteer_ack arrives in the same cycle as resteer, the FSM returns to IDLE on the next edge.
  - resteer_ack seen in IDLE is ignored.
- Counters:
  - br_count increments on every captured branch; mispred_count increments on every resteer.
  - Both stick at all-ones.
  - SETcc/CMOVcc (in_is_br=0) update neither counter.

Decomposition:
- Shared package holds:
  - flag bit index constants CF_B=0, PF_B=1, AF_B=2, ZF_B=3, SF_B=4, DF_B=7, OF_B=8;
  - the 4-bit tttn encodings;
  - FSM state encodings IDLE, SQUASH.
- One combinational sub-module, cc_eval (eff flags plus in_cond -> cond_true), shared later with the CMOV datapath. The FSM, register and counters live in cond_resolve.

Test Plan:
- cc=18'h008 (ZF=1), in_cond=4'h4, branch, pred_taken=1 -> out_cond_true=1 next cycle, no resteer, br_count=1.
- cc=0, in_cond=4'h4, pred_taken=1, in_fallthru=32'h1000 -> resteer pulse of 1 cycle with resteer_eip=32'h1000; in_ready=0 until resteer_ack; mispred_count=1.
- cc=0, cc_wr_valid=1, cc_wr_data=18'h110 (SF=1, OF=1), cc_wr_mask=18'h110, in_cond=4'hC (L) -> cond_true=0, because the bypassed SF^OF=0.
- out_ready held 0 for 3 cycles with back-to-back in_valid -> out_valid and data stable, in_ready=0; on out_ready=1, drain and fill occur in the same cycle.
- rst dropped low while in SQUASH with out_valid=1 -> immediately out_valid=0, resteer=0, counters 0; IDLE after release.
- Preload br_count=16'hFFFF via 65535 branches -> a further branch leaves it at 16'hFFFF.
